// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int START_IDX      = 0;
  localparam int FIRST_DATA_IDX = 1;

  function automatic int frame_bits(input int data, input int parity, input int stop);
    return 1 + data + parity + stop;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - tick-enabled modulo-N counter with wrap pulse
module tick_counter #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - oversample bit timer: mid-bit strobes, bit/frame ends, start-bit check
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1,
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS),
  localparam int HALF       = OVERSAMPLE / 2,
  localparam int SUB_W      = $clog2(OVERSAMPLE),
  localparam int BIT_W      = $clog2(FRAME_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  input  logic             rxd,
  output logic             busy,
  output logic             sample_stb,
  output logic [BIT_W-1:0] bit_idx,
  output logic             bit_end,
  output logic             frame_done,
  output logic             false_start
);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_EN < 0 || PARITY_EN > 1 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_rx_bit_timer: illegal parameter combination");
  end

  state_t           state, state_next;
  logic [SUB_W-1:0] sub_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             run_en, clr, sub_wrap, bit_wrap;
  logic             mid_q, false_q, sample_q, bit_end_q, done_q;

  // Abort gates the enable so no qualifier can fire on the aborting edge.
  assign run_en = (state == RUN) && tick && !abort;
  assign clr    = (state_next != RUN);

  tick_counter #(.N(OVERSAMPLE)) u_sub_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(run_en), .cnt(sub_cnt), .wrap(sub_wrap)
  );

  tick_counter #(.N(FRAME_BITS)) u_bit_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(sub_wrap), .cnt(bit_cnt), .wrap(bit_wrap)
  );

  assign mid_q     = run_en && (sub_cnt == SUB_W'(HALF - 1));
  assign false_q   = mid_q && (bit_cnt == BIT_W'(START_IDX)) && rxd;
  assign sample_q  = mid_q && !false_q;
  assign done_q    = bit_wrap;
  assign bit_end_q = sub_wrap && !bit_wrap;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !abort) state_next = RUN;
      RUN:     if (abort || done_q || false_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sample_stb  <= 1'b0;
      bit_end     <= 1'b0;
      frame_done  <= 1'b0;
      false_start <= 1'b0;
      bit_idx     <= '0;
    end else begin
      state       <= state_next;
      sample_stb  <= sample_q;
      bit_end     <= bit_end_q;
      frame_done  <= done_q;
      false_start <= false_q;
      if (sample_q) bit_idx <= bit_cnt;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb/tb_uart_rx_bit_timer.sv - self-checking bench for uart_rx_bit_timer (two parameter sets)
module tb_uart_rx_bit_timer;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst, tick, start, abort, rxd;
  logic busy1, smp1, be1, fd1, fs1;
  logic [3:0] idx1;
  logic busy2, smp2, be2, fd2, fs2;
  logic [3:0] idx2;

  int compared = 0;
  int mismatched = 0;

  uart_rx_bit_timer u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort), .rxd(rxd),
    .busy(busy1), .sample_stb(smp1), .bit_idx(idx1), .bit_end(be1),
    .frame_done(fd1), .false_start(fs1)
  );

  uart_rx_bit_timer #(.OVERSAMPLE(16), .DATA_BITS(7), .PARITY_EN(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort), .rxd(rxd),
    .busy(busy2), .sample_stb(smp2), .bit_idx(idx2), .bit_end(be2),
    .frame_done(fd2), .false_start(fs2)
  );

  always #5 clk = ~clk;

  // Reference: a frame is a run of ticks numbered 0..frame*os-1 within the frame.
  typedef struct {
    bit active;
    int pos;
    bit busy, smp, be, fd, fs;
    int idx;
  } model_t;

  typedef struct {
    bit rxd;
    int abort_t, start_t, rst_t;
    int s1, e1, d1, f1, b1;
    int s2, e2, d2, f2, b2;
  } vec_t;

  model_t m1, m2;
  int cs[2], ce[2], cd[2], cf[2], cb[2];

  function automatic model_t mstep(input model_t m, input int os, input int fb,
                                   input logic r, input logic t, input logic s,
                                   input logic a, input logic d);
    model_t n;
    int sub, b;
    n = m;
    n.smp = 0; n.be = 0; n.fd = 0; n.fs = 0;
    if (r) begin
      n = '{default: 0};
    end else if (m.active) begin
      if (a) begin
        n.active = 0;
      end else if (t) begin
        sub = m.pos % os;
        b = m.pos / os;
        n.pos = m.pos + 1;
        if (sub == os / 2 - 1) begin
          if (b == START_IDX && d) begin
            n.fs = 1; n.active = 0;
          end else begin
            n.smp = 1; n.idx = b;
          end
        end
        if (sub == os - 1) begin
          if (b == fb - 1) begin
            n.fd = 1; n.active = 0;
          end else begin
            n.be = 1;
          end
        end
      end
    end else if (s && !a) begin
      n.active = 1; n.pos = 0;
    end
    n.busy = n.active;
    return n;
  endfunction

  function automatic int pk(input logic b, input logic s, input logic e, input logic d,
                            input logic f, input logic [3:0] i);
    return int'({b, s, e, d, f, i});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    if (tick && busy1) cb[0]++;
    if (tick && busy2) cb[1]++;
    @(posedge clk);
    m1 = mstep(m1, 8, 10, rst, tick, start, abort, rxd);
    m2 = mstep(m2, 16, 11, rst, tick, start, abort, rxd);
    #1;
    chk("outs_os8", pk(busy1, smp1, be1, fd1, fs1, idx1),
        pk(m1.busy, m1.smp, m1.be, m1.fd, m1.fs, 4'(m1.idx)));
    chk("outs_os16", pk(busy2, smp2, be2, fd2, fs2, idx2),
        pk(m2.busy, m2.smp, m2.be, m2.fd, m2.fs, 4'(m2.idx)));
    cs[0] += int'(smp1); ce[0] += int'(be1); cd[0] += int'(fd1); cf[0] += int'(fs1);
    cs[1] += int'(smp2); ce[1] += int'(be2); cd[1] += int'(fd2); cf[1] += int'(fs2);
    rst = 0; tick = 0; start = 0; abort = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      repeat (3) cyc();
      tick = 1;
      cyc();
    end
  endtask

  vec_t tbl[5];
  int found;

  initial begin
    // rxd, abort_t, start_t, rst_t, then {samples, bit_ends, dones, false, busy ticks} per DUT
    tbl[0] = '{0, 0, 0, 0, 10, 9, 1, 0, 80, 11, 10, 1, 0, 176};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 8};
    tbl[2] = '{0, 30, 0, 0, 4, 3, 0, 0, 30, 2, 1, 0, 0, 30};
    tbl[3] = '{0, 0, 40, 0, 10, 9, 1, 0, 80, 11, 10, 1, 0, 176};
    tbl[4] = '{0, 0, 0, 50, 6, 6, 0, 0, 50, 3, 3, 0, 0, 50};

    m1 = '{default: 0};
    m2 = '{default: 0};
    rst = 1; tick = 0; start = 0; abort = 0; rxd = 0;
    cyc();
    rst = 1;
    cyc();
    chk("reset_state", pk(busy1, smp1, be1, fd1, fs1, idx1), 0);

    foreach (tbl[k]) begin
      rst = 1;
      cyc();
      for (int j = 0; j < 2; j++) begin
        cs[j] = 0; ce[j] = 0; cd[j] = 0; cf[j] = 0; cb[j] = 0;
      end
      rxd = tbl[k].rxd;
      start = 1;
      cyc();
      for (int t = 1; t <= 200; t++) begin
        repeat (3) cyc();
        tick = 1;
        abort = (t == tbl[k].abort_t);
        start = (t == tbl[k].start_t);
        rst = (t == tbl[k].rst_t);
        cyc();
      end
      rxd = 0;
      chk($sformatf("vec%0d_samples_os8", k), cs[0], tbl[k].s1);
      chk($sformatf("vec%0d_bit_ends_os8", k), ce[0], tbl[k].e1);
      chk($sformatf("vec%0d_dones_os8", k), cd[0], tbl[k].d1);
      chk($sformatf("vec%0d_false_os8", k), cf[0], tbl[k].f1);
      chk($sformatf("vec%0d_busy_ticks_os8", k), cb[0], tbl[k].b1);
      chk($sformatf("vec%0d_samples_os16", k), cs[1], tbl[k].s2);
      chk($sformatf("vec%0d_bit_ends_os16", k), ce[1], tbl[k].e2);
      chk($sformatf("vec%0d_dones_os16", k), cd[1], tbl[k].d2);
      chk($sformatf("vec%0d_false_os16", k), cf[1], tbl[k].f2);
      chk($sformatf("vec%0d_busy_ticks_os16", k), cb[1], tbl[k].b2);
    end

    // back-to-back: start in the frame_done cycle, no gap tick
    rst = 1; cyc();
    start = 1; cyc();
    found = 0;
    for (int t = 1; t <= 100 && found == 0; t++) begin
      ticks(1);
      if (fd1) found = 1;
    end
    chk("b2b_frame_done_seen", found, 1);
    start = 1; cyc();
    chk("b2b_busy", int'(busy1), 1);
    ticks(3);
    chk("b2b_no_early_sample", int'(smp1), 0);
    ticks(1);
    chk("b2b_first_sample", int'(smp1), 1);
    chk("b2b_first_idx", int'(idx1), START_IDX);
    ticks(8);
    chk("b2b_data_sample", int'(smp1), 1);
    chk("b2b_data_idx", int'(idx1), FIRST_DATA_IDX);

    // abort at tick 30, restart two cycles later
    rst = 1; cyc();
    start = 1; cyc();
    for (int t = 1; t <= 30; t++) begin
      repeat (3) cyc();
      tick = 1; abort = (t == 30);
      cyc();
    end
    chk("abort_busy", int'(busy1), 0);
    cyc();
    start = 1; cyc();
    chk("restart_busy", int'(busy1), 1);
    ticks(4);
    chk("restart_sample", int'(smp1), 1);
    chk("restart_idx", int'(idx1), START_IDX);

    // rst at tick 50 with tick then held low
    rst = 1; cyc();
    start = 1; cyc();
    for (int t = 1; t <= 50; t++) begin
      repeat (3) cyc();
      tick = 1; rst = (t == 50);
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      chk("rst_hold_outs", pk(busy1, smp1, be1, fd1, fs1, idx1), 0);
      cyc();
    end
    start = 1; cyc();
    ticks(3);
    chk("post_rst_no_early_sample", int'(smp1), 0);
    ticks(1);
    chk("post_rst_sample", int'(smp1), 1);
    chk("post_rst_idx", int'(idx1), START_IDX);

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      tick  = ($urandom % 3) == 0;
      start = ($urandom % 8) == 0;
      abort = ($urandom % 300) == 0;
      rst   = ($urandom % 1000) == 0;
      rxd   = ($urandom % 6) == 0;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
